uart_serial_tx: RTL and testbench

Synthesizable 8-bit UART transmitter. The system side presents bytes over a ready/valid handshake, and the block serializes them onto `o_uart_tx` as 8N1 frames, or 8E1/8O1 frames when parity is compiled in. It is the DUT-side sender that drives the `i_uart_rx` input of the UART simulation transactor. A one-byte holding register lets consecutive frames go out with no idle gap.

---
 rtl/uart_serial_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_serial_tx.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_serial_tx.sv
// ---------------------------------------------------------------------------
// uart_serial_tx
//
// Purpose:
//   8-bit UART transmitter. Bytes arrive over a ready/valid handshake into a
//   one-byte holding register, then a shifter FSM serializes them onto the
//   line as 8N1 frames (or 8E1/8O1 when parity is compiled in), with one or
//   two stop bits. The holding register allows back-to-back frames with no
//   idle gap: the edge that ends the final stop bit also starts the next
//   start bit.
//
// Build option:
//   UART_SERIAL_TX_PARITY_EN - when defined, a parity bit is inserted after
//   data bit 7; PARITY_ODD selects its sense (0 even, 1 odd). When undefined
//   there is no parity state or logic and PARITY_ODD is only range-checked.
//
// Parameters:
//   CLOCKS_PER_BIT - i_clock cycles per serial bit (>= 2)
//   STOP_BITS      - number of stop bits (1 or 2)
//   PARITY_ODD     - parity sense, used only with the parity build option
//
// Ports:
//   i_clock          in   single clock, rising edge
//   i_reset          in   synchronous active-high reset
//   i_tx_data        in   byte to send
//   i_tx_data_valid  in   i_tx_data is valid
//   o_tx_data_ready  out  holding register can accept a byte
//   o_uart_tx        out  registered serial line, idles high
//   o_busy           out  frame in progress or holding register full
// ---------------------------------------------------------------------------
module uart_serial_tx #(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_ODD     = 0
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_data_valid,
    output logic       o_tx_data_ready,
    output logic       o_uart_tx,
    output logic       o_busy
);

    localparam int                BAUD_W    = $clog2(CLOCKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    // Illegal parameter combinations stop elaboration rather than building
    // a transmitter with a silently wrong frame format.
    if (CLOCKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_serial_tx: illegal parameter value");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_SERIAL_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // Registers and their next-state values
    // -----------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic [BAUD_W-1:0]   baud_cnt_q,   baud_cnt_d;
    logic [2:0]          bit_cnt_q,    bit_cnt_d;
    logic [7:0]          shift_q,      shift_d;
    logic                tx_q,         tx_d;
    logic [7:0]          hold_data_q,  hold_data_d;
    logic                hold_valid_q, hold_valid_d;
`ifdef UART_SERIAL_TX_PARITY_EN
    localparam logic     PAR_ODD = (PARITY_ODD != 0);
    logic                parity_q,     parity_d;
`endif

    logic accept;
    logic baud_wrap;
    logic load_shift;

    assign o_tx_data_ready = !i_reset && !hold_valid_q;
    assign accept          = i_tx_data_valid && o_tx_data_ready;
    assign baud_wrap       = (baud_cnt_q == BAUD_LAST);

    // -----------------------------------------------------------------------
    // Process 1: state register (all sequential state lives here)
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
`ifdef UART_SERIAL_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
`ifdef UART_SERIAL_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Process 2: next-state logic for the shifter FSM, its counters and the
    // holding register
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        load_shift   = 1'b0;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;

        // The baud counter free-runs whenever a frame is on the line.
        if (state_q != ST_IDLE) begin
            baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + BAUD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_valid_q) begin
                    state_d    = ST_START;
                    load_shift = 1'b1;
                end
            end
            ST_START: begin
                if (baud_wrap) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (baud_wrap) begin
                    // LSB first: the next data bit always sits in shift_q[0].
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
`ifdef UART_SERIAL_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_wrap) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
`endif
            ST_STOP: begin
                if (baud_wrap) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        // Chaining straight into the next start bit is what
                        // makes back-to-back frames gapless.
                        if (hold_valid_q) begin
                            state_d    = ST_START;
                            load_shift = 1'b1;
                        end else begin
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_shift) begin
            shift_d      = hold_data_q;
            baud_cnt_d   = '0;
            bit_cnt_d    = '0;
            hold_valid_d = 1'b0;
        end

        // Loading and accepting can never coincide: loading needs a full
        // holding register, accepting needs an empty one.
        if (accept) begin
            hold_data_d  = i_tx_data;
            hold_valid_d = 1'b1;
        end
    end

`ifdef UART_SERIAL_TX_PARITY_EN
    // Parity is computed once, from the whole byte, as it enters the shifter.
    always_comb begin
        parity_d = parity_q;
        if (load_shift) begin
            parity_d = (^hold_data_q) ^ PAR_ODD;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Process 3: output logic. The line value for the upcoming state is
    // registered so o_uart_tx is glitch-free and switches on the same edge
    // as the state.
    // -----------------------------------------------------------------------
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_SERIAL_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    assign o_uart_tx = tx_q;
    assign o_busy    = (state_q != ST_IDLE) || hold_valid_q;

endmodule

// File: tb/tb_uart_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_serial_tx
//
// Two transmitters with CLOCKS_PER_BIT=4: instance 0 has one stop bit and
// even parity sense, instance 1 has two stop bits and odd parity sense.
// The driver pushes each accepted byte, with the cycle its start bit must
// appear, into a per-instance queue; a monitor per instance follows the
// line every cycle, pops and compares whole frames, and also checks ready
// and busy against a small hold/busy window model kept by the driver.
// Cycle numbering: cyc counts rising edges; values are sampled 1 time unit
// after each rising edge, inputs change on falling edges.
// ---------------------------------------------------------------------------
module tb_uart_serial_tx;

    localparam int CPB = 4;
`ifdef UART_SERIAL_TX_PARITY_EN
    localparam int PBIT = 1;
`else
    localparam int PBIT = 0;
`endif

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clk = 1'b0;
    logic [1:0] rst_w   = 2'b11;
    logic [1:0] valid_w = 2'b00;
    logic [7:0] data_w [2];
    logic [1:0] ready_w;
    logic [1:0] tx_w;
    logic [1:0] busy_w;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Hold/busy window model, written by the driver, read by the monitors.
    int hold_from [2] = '{0, 0};
    int hold_to   [2] = '{0, 0};
    int busy_from [2] = '{0, 0};
    int busy_to   [2] = '{0, 0};
    int last_end  [2] = '{0, 0};
    int last_start[2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        uart_serial_tx #(
            .CLOCKS_PER_BIT(CPB),
            .STOP_BITS     (gi + 1),
            .PARITY_ODD    (gi)
        ) u_dut (
            .i_clock        (clk),
            .i_reset        (rst_w[gi]),
            .i_tx_data      (data_w[gi]),
            .i_tx_data_valid(valid_w[gi]),
            .o_tx_data_ready(ready_w[gi]),
            .o_uart_tx      (tx_w[gi]),
            .o_busy         (busy_w[gi])
        );
    end

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic void chk(input string name, input int id,
                                input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc %0d: got %b, expected %b",
                     name, id, cyc, act, exp);
        end
    endfunction

    function automatic void chk_int(input string name, input int id,
                                    input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc %0d: got %0d, expected %0d",
                     name, id, cyc, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name, input int id);
        vectors++;
        miscompares++;
        $display("FAIL %s dut%0d cyc %0d: event did not occur as required",
                 name, id, cyc);
    endfunction

    function automatic int frame_len(input int id);
        return (10 + PBIT + id) * CPB;
    endfunction

    function automatic int qsize(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int id);
        if (id == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic int qfront_start(input int id);
        return (id == 0) ? q0[0].start : q1[0].start;
    endfunction

    function automatic void qpush(input int id, input exp_t e);
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endfunction

    function automatic void qflush(input int id);
        if (id == 0) q0.delete();
        else         q1.delete();
    endfunction

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    // Presents a byte and leaves valid high; the caller follows with drop()
    // or another send(), so valid can be held across back-to-back bytes.
    task automatic send(input int id, input logic [7:0] b);
        exp_t e;
        int   n  = 0;
        int   e0;
        @(negedge clk);
        data_w[id]  = b;
        valid_w[id] = 1'b1;
        while (!ready_w[id] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ready_w[id]) begin
            fail_now("ready_timeout", id);
            valid_w[id] = 1'b0;
            return;
        end
        e0      = cyc + 1;
        e.data  = b;
        e.start = (e0 + 1 > last_end[id]) ? e0 + 1 : last_end[id];
        if (e0 >= busy_to[id]) busy_from[id] = e0;
        hold_from[id]  = e0;
        hold_to[id]    = e.start;
        last_start[id] = e.start;
        last_end[id]   = e.start + frame_len(id);
        busy_to[id]    = last_end[id];
        qpush(id, e);
    endtask

    task automatic drop(input int id);
        @(negedge clk);
        valid_w[id] = 1'b0;
    endtask

    // One-cycle valid pulse, issued only where the model has the holding
    // register full, so the byte must be ignored.
    task automatic pulse(input int id, input logic [7:0] b);
        @(negedge clk);
        data_w[id]  = b;
        valid_w[id] = 1'b1;
        @(negedge clk);
        valid_w[id] = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        while ((cyc < last_end[id] + 2 || qsize(id) != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail_now("idle_timeout", id);
    endtask

    task automatic do_reset(input int id, input int ncyc);
        @(negedge clk);
        rst_w[id]      = 1'b1;
        valid_w[id]    = 1'b0;
        hold_from[id]  = 0;
        hold_to[id]    = 0;
        busy_from[id]  = 0;
        busy_to[id]    = 0;
        last_end[id]   = 0;
        repeat (ncyc) @(negedge clk);
        rst_w[id] = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Monitor: one per instance, pops an expected frame at each start bit
    // -----------------------------------------------------------------------
    task automatic monitor(input int id);
        exp_t        cur;
        bit          active = 1'b0;
        int          pos    = 0;
        int          nbits  = 10 + PBIT + id;
        logic [15:0] bits   = '1;
        logic        exp_ready;
        logic        exp_busy;
        forever begin
            @(posedge clk);
            #1;
            if (rst_w[id]) begin
                active = 1'b0;
                qflush(id);
                chk("reset_tx", id, tx_w[id], 1'b1);
                chk("reset_busy", id, busy_w[id], 1'b0);
                chk("reset_ready", id, ready_w[id], 1'b0);
            end else begin
                exp_ready = !(cyc >= hold_from[id] && cyc < hold_to[id]);
                exp_busy  = (cyc >= busy_from[id] && cyc < busy_to[id]);
                chk("ready", id, ready_w[id], exp_ready);
                chk("busy", id, busy_w[id], exp_busy);
                if (!active) begin
                    if (tx_w[id] == 1'b0) begin
                        if (qsize(id) == 0) begin
                            fail_now("spurious_start", id);
                        end else begin
                            cur = qpop(id);
                            chk_int("start_cycle", id, cyc, cur.start);
                            bits = '1;
                            bits[0] = 1'b0;
                            for (int i = 0; i < 8; i++) bits[1 + i] = cur.data[i];
                            if (PBIT == 1) bits[9] = (^cur.data) ^ (id == 1);
                            active = 1'b1;
                            pos    = 0;
                        end
                    end else if (qsize(id) != 0 && cyc > qfront_start(id)) begin
                        fail_now("missing_start", id);
                        cur = qpop(id);
                    end
                end
                if (active) begin
                    chk("line_bit", id, tx_w[id], bits[pos / CPB]);
                    pos++;
                    if (pos == nbits * CPB) begin
                        active = 1'b0;
                        $display("dut%0d frame 0x%02h start %0d end %0d (%0d cycles)",
                                 id, cur.data, cur.start, cyc, nbits * CPB);
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Directed stimulus
    // -----------------------------------------------------------------------
    initial begin
        data_w[0] = 8'h00;
        data_w[1] = 8'h00;
        rst_w     = 2'b11;
        valid_w   = 2'b00;
        repeat (3) @(negedge clk);
        rst_w = 2'b00;
        repeat (6) @(negedge clk);

        // Single frame 0x55.
        send(0, 8'h55);
        drop(0);
        wait_idle(0);

        // Back-to-back 0xA5, 0x3C with valid held high.
        send(0, 8'hA5);
        send(0, 8'h3C);
        drop(0);
        wait_idle(0);

        // Parity sense on both instances (parity bit present only when built in).
        send(0, 8'h07);
        drop(0);
        wait_idle(0);
        send(1, 8'h07);
        drop(1);
        wait_idle(1);

        // Reset during data bit 3 of 0xF0, then a clean 0x81 frame.
        send(0, 8'hF0);
        drop(0);
        while (cyc < last_start[0] + 4 * CPB + 1) @(negedge clk);
        do_reset(0, 1);
        repeat (20) @(negedge clk);
        send(0, 8'h81);
        drop(0);
        wait_idle(0);

        // Two stop bits: dropped valid while the holding register is full.
        send(1, 8'h12);
        send(1, 8'h34);
        drop(1);
        repeat (3) @(negedge clk);
        pulse(1, 8'h99);
        wait_idle(1);
        send(1, 8'hFF);
        drop(1);
        wait_idle(1);

        // A zero byte on the one-stop-bit instance.
        send(0, 8'h00);
        drop(0);
        wait_idle(0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
